// File: rtl/prng_arbiter.sv
// rtl/prng_arbiter.sv - round-robin arbiter handing out LCG-derived random bytes, with per-frame replay
module prng_arbiter #(
  parameter logic [15:0] MULT     = 16'h5851,
  parameter logic [15:0] INC      = 16'h1405,
  parameter logic [15:0] RST_SEED = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic        seed_load,
  input  logic [15:0] seed,
  input  logic        frame_start,
  input  logic        replay_en,
  output logic [3:0]  gnt,
  output logic [7:0]  rnd,
  output logic        rnd_valid,
  output logic [1:0]  last_gnt
);

  logic [15:0] s_q, s_d;
  logic [15:0] fs_q, fs_d;
  logic [3:0]  gnt_q, gnt_d;
  logic [7:0]  rnd_q, rnd_d;
  logic        rnd_valid_q, rnd_valid_d;
  logic [1:0]  last_gnt_q, last_gnt_d;

  logic        found;
  logic [1:0]  winner;
  logic [1:0]  cand;
  logic [7:0]  xs;
  logic [2:0]  rot;
  logic [2:0]  src;
  logic [7:0]  perm;

  always_comb begin
    // Round-robin scan starting just past the previous winner.
    found  = 1'b0;
    winner = 2'd0;
    cand   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      cand = last_gnt_q + 2'd1 + 2'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end

    // xs is bits [10:3] of (s >> 1) ^ s; top three state bits pick the rotation.
    xs   = s_q[11:4] ^ s_q[10:3];
    rot  = s_q[15:13];
    perm = 8'd0;
    src  = 3'd0;
    for (int j = 0; j < 8; j++) begin
      src     = 3'(j) + rot;
      perm[j] = xs[src];
    end

    s_d         = s_q;
    fs_d        = fs_q;
    gnt_d       = 4'd0;
    rnd_d       = rnd_q;
    rnd_valid_d = 1'b0;
    last_gnt_d  = last_gnt_q;

    if (seed_load) begin
      s_d  = seed;
      fs_d = seed;
    end else if (frame_start && replay_en) begin
      s_d = fs_q;
    end else if (found) begin
      s_d         = s_q * MULT + INC;
      gnt_d       = 4'b0001 << winner;
      rnd_d       = perm;
      rnd_valid_d = 1'b1;
      last_gnt_d  = winner;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q         <= RST_SEED;
      fs_q        <= RST_SEED;
      gnt_q       <= 4'd0;
      rnd_q       <= 8'd0;
      rnd_valid_q <= 1'b0;
      last_gnt_q  <= 2'd3;
    end else begin
      s_q         <= s_d;
      fs_q        <= fs_d;
      gnt_q       <= gnt_d;
      rnd_q       <= rnd_d;
      rnd_valid_q <= rnd_valid_d;
      last_gnt_q  <= last_gnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign rnd       = rnd_q;
  assign rnd_valid = rnd_valid_q;
  assign last_gnt  = last_gnt_q;

endmodule

// File: tb/tb_prng_arbiter.sv
// tb/tb_prng_arbiter.sv - directed self-checking bench for prng_arbiter
module tb_prng_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req;
  logic        seed_load;
  logic [15:0] seed;
  logic        frame_start;
  logic        replay_en;
  logic [3:0]  gnt;
  logic [7:0]  rnd;
  logic        rnd_valid;
  logic [1:0]  last_gnt;

  int checks = 0;
  int errors = 0;
  logic [15:0] mdl_s;
  logic [7:0]  mdl_rnd;

  prng_arbiter dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .seed_load   (seed_load),
    .seed        (seed),
    .frame_start (frame_start),
    .replay_en   (replay_en),
    .gnt         (gnt),
    .rnd         (rnd),
    .rnd_valid   (rnd_valid),
    .last_gnt    (last_gnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] m_next(input logic [15:0] s);
    return s * 16'h5851 + 16'h1405;
  endfunction

  function automatic logic [7:0] m_byte(input logic [15:0] s);
    logic [15:0] t;
    logic [7:0]  x;
    logic [15:0] w;
    t = (s >> 1) ^ s;
    x = t[10:3];
    w = {x, x} >> s[15:13];
    return w[7:0];
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input string tag, input logic [3:0] exp_gnt);
    mdl_rnd = m_byte(mdl_s);
    mdl_s   = m_next(mdl_s);
    tick();
    chk({tag, "_gnt"}, 16'(gnt), 16'(exp_gnt));
    chk({tag, "_rnd"}, 16'(rnd), 16'(mdl_rnd));
    chk({tag, "_vld"}, 16'(rnd_valid), 16'd1);
  endtask

  task automatic idle(input string tag);
    tick();
    chk({tag, "_gnt"}, 16'(gnt), 16'd0);
    chk({tag, "_vld"}, 16'(rnd_valid), 16'd0);
    chk({tag, "_rnd_hold"}, 16'(rnd), 16'(mdl_rnd));
  endtask

  initial begin
    rst_n = 1'b0; req = 4'd0; seed_load = 1'b0; seed = 16'd0;
    frame_start = 1'b0; replay_en = 1'b0;
    #1;
    tick(); tick();
    rst_n = 1'b1;
    mdl_s = 16'h0000; mdl_rnd = 8'h00;
    chk("rst_gnt", 16'(gnt), 16'd0);
    chk("rst_rnd", 16'(rnd), 16'd0);
    chk("rst_vld", 16'(rnd_valid), 16'd0);
    chk("rst_last", 16'(last_gnt), 16'd3);

    // Single requester, hand-computed bytes from s = 0000, 1405, 219A
    req = 4'b0001;
    issue("single0", 4'b0001); chk("single0_hand", 16'(rnd), 16'h00);
    issue("single1", 4'b0001); chk("single1_hand", 16'(rnd), 16'hC0);
    issue("single2", 4'b0001); chk("single2_hand", 16'(rnd), 16'h15);
    req = 4'b0000;
    idle("noreq");
    chk("noreq_last", 16'(last_gnt), 16'd0);

    // All four requesting: strict rotation, no gaps
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    mdl_s = 16'h0000; mdl_rnd = 8'h00;
    req = 4'b1111;
    for (int i = 0; i < 8; i++) issue("rr4", 4'b0001 << (i % 4));

    // Two requesters, last_gnt forced to 1 first
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    mdl_s = 16'h0000; mdl_rnd = 8'h00;
    req = 4'b0010;
    issue("pre_rr2", 4'b0010);
    chk("pre_rr2_last", 16'(last_gnt), 16'd1);
    req = 4'b1010;
    issue("rr2_a", 4'b1000);
    issue("rr2_b", 4'b0010);
    issue("rr2_c", 4'b1000);
    issue("rr2_d", 4'b0010);

    // Seed load suppresses the issue, next byte from BEEF
    req = 4'b1111; seed = 16'hBEEF; seed_load = 1'b1;
    idle("seedld");
    seed_load = 1'b0;
    mdl_s = 16'hBEEF;
    issue("beef", 4'b0100);
    chk("beef_hand", 16'(rnd), 16'h99);

    // Replay: same ten bytes after frame_start
    req = 4'b0001; seed = 16'h1234; seed_load = 1'b1; replay_en = 1'b1;
    idle("seed1234");
    seed_load = 1'b0;
    mdl_s = 16'h1234;
    for (int i = 0; i < 10; i++) issue("play1", 4'b0001);
    frame_start = 1'b1;
    idle("replay_fs");
    frame_start = 1'b0;
    mdl_s = 16'h1234;
    for (int i = 0; i < 10; i++) issue("play2", 4'b0001);
    replay_en = 1'b0; frame_start = 1'b1;
    issue("noreplay", 4'b0001);
    frame_start = 1'b0;

    // Seed load beats frame_start; frame-seed register also takes the seed
    seed = 16'hBEEF; seed_load = 1'b1; frame_start = 1'b1; replay_en = 1'b1;
    idle("seed_vs_fs");
    seed_load = 1'b0; frame_start = 1'b0;
    mdl_s = 16'hBEEF;
    issue("sfs0", 4'b0001);
    chk("sfs0_hand", 16'(rnd), 16'h99);
    issue("sfs1", 4'b0001);
    frame_start = 1'b1;
    idle("sfs_replay");
    frame_start = 1'b0;
    mdl_s = 16'hBEEF;
    issue("sfs2", 4'b0001);
    chk("sfs2_hand", 16'(rnd), 16'h99);
    replay_en = 1'b0;

    // Reset mid-stream discards the in-flight grant
    req = 4'b1111;
    tick();
    rst_n = 1'b0;
    tick();
    chk("midrst_gnt", 16'(gnt), 16'd0);
    chk("midrst_vld", 16'(rnd_valid), 16'd0);
    chk("midrst_rnd", 16'(rnd), 16'd0);
    chk("midrst_last", 16'(last_gnt), 16'd3);
    rst_n = 1'b1; req = 4'b0000;
    mdl_rnd = 8'h00;
    idle("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
